// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// usb_pkg : shared constants and FSM state type for the USB serial transmitter
// Revision : 1.0
// ============================================================================
package usb_pkg;

    localparam int         CLKS_PER_BIT_DEF = 8;
    localparam int         WORD_BITS        = 16;
    localparam logic [2:0] STUFF_LIMIT      = 3'd6;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_DATA0 = 8'hC3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND    = 3'd2,
        ST_STUFF   = 3'd3,
        ST_EOP_SE0 = 3'd4,
        ST_EOP_J   = 3'd5
    } tx_state_e;

    // Wire order is byte [15:8] then [7:0], each LSB first; swapping the
    // bytes lets a plain right shift present bits in transmit order.
    function automatic logic [15:0] wire_order(input logic [15:0] word);
        return {word[7:0], word[15:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// usb_tx_encoder : bit timer, NRZI line state, bit stuffing and D+/D- drive
// Revision : 1.0
// ============================================================================
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic pkt_start_i,
    input  logic bit_valid_i,
    input  logic bit_i,
    input  logic drive_j_i,
    input  logic drive_se0_i,
    output logic bit_done_o,
    output logic stuff_start_o,
    output logic d_plus_o,
    output logic d_minus_o
);

    localparam int            TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    ones_q, ones_d;
    logic          line_q, line_d;
    logic          active_q, active_d;
    logic          d_plus_q, d_minus_q;
    logic          w_bit_end, w_stuff_due;

    assign w_bit_end     = active_q && (timer_q == BIT_LAST);
    assign w_stuff_due   = (ones_q == STUFF_LIMIT);
    assign stuff_start_o = w_bit_end && w_stuff_due;
    assign bit_done_o    = w_bit_end && !w_stuff_due;

    // line_q is the NRZI level, 1 meaning J; a stuff bit is a forced toggle
    // inserted before bit_done_o is offered for the next data bit.
    always_comb begin
        timer_d  = active_q ? timer_q + 1'b1 : timer_q;
        ones_d   = ones_q;
        line_d   = line_q;
        active_d = active_q;
        if (drive_j_i || drive_se0_i) begin
            timer_d  = '0;
            ones_d   = '0;
            line_d   = 1'b1;
            active_d = 1'b0;
        end else if (pkt_start_i && bit_valid_i) begin
            timer_d  = '0;
            active_d = 1'b1;
            line_d   = bit_i;
            ones_d   = {2'b00, bit_i};
        end else if (stuff_start_o) begin
            timer_d = '0;
            line_d  = ~line_q;
            ones_d  = '0;
        end else if (bit_done_o) begin
            timer_d = '0;
            if (bit_valid_i) begin
                line_d = bit_i ? line_q : ~line_q;
                ones_d = bit_i ? ones_q + 3'd1 : 3'd0;
            end else begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            timer_q   <= '0;
            ones_q    <= '0;
            line_q    <= 1'b1;
            active_q  <= 1'b0;
            d_plus_q  <= 1'b1;
            d_minus_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            ones_q    <= ones_d;
            line_q    <= line_d;
            active_q  <= active_d;
            d_plus_q  <= drive_se0_i ? 1'b0 : line_d;
            d_minus_q <= drive_se0_i ? 1'b0 : ~line_d;
        end
    end

    assign d_plus_o  = d_plus_q;
    assign d_minus_o = d_minus_q;

endmodule
`default_nettype wire

// File: rtl/usb_tx_top_level.sv
`default_nettype none
// ============================================================================
// usb_tx_top_level : packet FSM, word shift register and FIFO handshake
// Revision : 1.0
// ============================================================================
module usb_tx_top_level
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [15:0] tx_data,
    input  logic        transmit_empty,
    input  logic        transmit_start,
    output logic        d_plus_out,
    output logic        d_minus_out,
    output logic        read_enable,
    output logic        tx_error
);

    localparam int            EW       = $clog2(2 * CLKS_PER_BIT + 1);
    localparam logic [EW-1:0] SE0_LAST = EW'(2 * CLKS_PER_BIT - 1);
    localparam logic [EW-1:0] J_LAST   = EW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BIT_LAST = 4'(WORD_BITS - 1);

    tx_state_e     state_q, state_d;
    logic [15:0]   sr_q, sr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [EW-1:0] eop_q, eop_d;
    logic          start_q, start_prev_q, tx_error_q;
    logic          w_pop, w_bit_valid, w_bit, w_pkt_start;
    logic          w_bit_done, w_stuff_start;
    logic          w_drive_j, w_drive_se0;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        eop_d       = eop_q;
        w_pop       = 1'b0;
        w_bit_valid = 1'b0;
        w_bit       = 1'b0;
        w_pkt_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_pop       = 1'b1;
                w_pkt_start = 1'b1;
                w_bit_valid = 1'b1;
                w_bit       = tx_data[8];
                sr_d        = wire_order(tx_data);
                cnt_d       = '0;
                state_d     = ST_SEND;
            end
            ST_SEND, ST_STUFF: begin
                if (w_stuff_start) begin
                    state_d = ST_STUFF;
                end else if (w_bit_done) begin
                    state_d = ST_SEND;
                    if (cnt_q != BIT_LAST) begin
                        w_bit_valid = 1'b1;
                        w_bit       = sr_q[1];
                        sr_d        = sr_q >> 1;
                        cnt_d       = cnt_q + 4'd1;
                    end else if (!transmit_empty) begin
                        // Next word follows with no gap on the wire.
                        w_pop       = 1'b1;
                        w_bit_valid = 1'b1;
                        w_bit       = tx_data[8];
                        sr_d        = wire_order(tx_data);
                        cnt_d       = '0;
                    end else begin
                        state_d = ST_EOP_SE0;
                        eop_d   = '0;
                    end
                end
            end
            ST_EOP_SE0: begin
                eop_d = eop_q + 1'b1;
                if (eop_q == SE0_LAST) begin
                    state_d = ST_EOP_J;
                    eop_d   = '0;
                end
            end
            ST_EOP_J: begin
                eop_d = eop_q + 1'b1;
                if (eop_q == J_LAST) begin
                    state_d = ST_IDLE;
                    eop_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_drive_j   = (state_d == ST_IDLE) || (state_d == ST_EOP_J);
    assign w_drive_se0 = (state_d == ST_EOP_SE0);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            eop_q        <= '0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            tx_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            eop_q        <= eop_d;
            start_q      <= transmit_start;
            start_prev_q <= start_q;
            // Edge-detected so a start held as a level does not flag an error.
            tx_error_q   <= start_q && !start_prev_q && (state_q != ST_IDLE);
        end
    end

    usb_tx_encoder #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_encoder (
        .clk           (clk),
        .n_rst         (n_rst),
        .pkt_start_i   (w_pkt_start),
        .bit_valid_i   (w_bit_valid),
        .bit_i         (w_bit),
        .drive_j_i     (w_drive_j),
        .drive_se0_i   (w_drive_se0),
        .bit_done_o    (w_bit_done),
        .stuff_start_o (w_stuff_start),
        .d_plus_o      (d_plus_out),
        .d_minus_o     (d_minus_out)
    );

    // Gated by reset so a reset landing on a word boundary never pops the FIFO.
    assign read_enable = w_pop && n_rst;
    assign tx_error    = tx_error_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_top_level.sv
`default_nettype none
// ============================================================================
// tb_usb_tx_top_level : directed packets checked against a wire-level model
// Revision : 1.0
// ============================================================================
module tb_usb_tx_top_level;

    localparam int CPB  = 8;
    localparam int MAXC = 8000;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] tx_data;
    logic        transmit_empty;
    logic        transmit_start = 1'b0;
    logic        d_plus_out, d_minus_out, read_enable, tx_error;

    usb_tx_top_level #(.CLKS_PER_BIT(CPB)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .tx_data        (tx_data),
        .transmit_empty (transmit_empty),
        .transmit_start (transmit_start),
        .d_plus_out     (d_plus_out),
        .d_minus_out    (d_minus_out),
        .read_enable    (read_enable),
        .tx_error       (tx_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: pkt_w[0..pkt_n-1] popped by read_enable
    logic [15:0] pkt_w [0:31];
    int pkt_n = 0;
    int pops  = 0;
    int base  = 0;
    int fidx;
    always @(posedge clk) if (read_enable) pops <= pops + 1;
    always_comb begin
        fidx           = pops - base;
        transmit_empty = (fidx >= pkt_n);
        tx_data        = (fidx >= 0 && fidx < pkt_n && fidx < 32) ? pkt_w[fidx] : 16'h0000;
    end

    // Expected per-cycle wire/handshake timeline
    typedef struct { int c; logic dp; logic dm; logic re; } exp_t;
    exp_t exp_q[$];
    int   model_bits;

    logic wdp [0:MAXC-1];
    logic wdm [0:MAXC-1];
    int   re_cnt = 0;
    int   err_cnt = 0;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            wdp[cyc] <= d_plus_out;
            wdm[cyc] <= d_minus_out;
        end
        if (read_enable) re_cnt <= re_cnt + 1;
        if (tx_error)    err_cnt <= err_cnt + 1;
        if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("line{dp,dm,re}", {d_plus_out, d_minus_out, read_enable}, {e.dp, e.dm, e.re});
        end
    end

    task automatic emit(input logic b, inout int cc, inout logic lvl);
        if (!b) lvl = ~lvl;
        for (int i = 0; i < CPB; i++) begin
            exp_q.push_back('{cc, lvl, ~lvl, 1'b0});
            cc++;
        end
        model_bits++;
    endtask

    // c is the idle cycle before LOAD; first bit time starts at c+2.
    task automatic build_expect(input int c);
        int   cc;
        logic lvl;
        int   ones;
        logic b;
        exp_t e;
        exp_q.push_back('{c, 1'b1, 1'b0, 1'b0});
        exp_q.push_back('{c + 1, 1'b1, 1'b0, 1'b1});
        cc = c + 2; lvl = 1'b1; ones = 0; model_bits = 0;
        for (int wi = 0; wi < pkt_n; wi++) begin
            for (int k = 0; k < 16; k++) begin
                b = (k < 8) ? pkt_w[wi][k + 8] : pkt_w[wi][k - 8];
                emit(b, cc, lvl);
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    emit(1'b0, cc, lvl);
                    ones = 0;
                end
            end
            if (wi < pkt_n - 1) begin
                e = exp_q.pop_back();
                e.re = 1'b1;
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < 2 * CPB; i++) begin exp_q.push_back('{cc, 1'b0, 1'b0, 1'b0}); cc++; end
        for (int i = 0; i < CPB + 4; i++) begin exp_q.push_back('{cc, 1'b1, 1'b0, 1'b0}); cc++; end
    endtask

    // Loop-back style receiver over the captured wire
    logic [7:0] dec_bytes [0:63];
    int dec_n, dec_wire, dec_left, dec_stuff_err;

    task automatic decode(input int s);
        int         t;
        logic       prev;
        logic       b;
        int         ones;
        int         nb;
        logic [7:0] cur;
        prev = 1'b1; ones = 0; nb = 0; cur = 8'h00;
        dec_n = 0; dec_wire = 0; dec_stuff_err = 0;
        t = s + CPB / 2;
        while (t < MAXC && dec_n < 64) begin
            if (!wdp[t] && !wdm[t]) break;
            b = (wdp[t] == prev);
            prev = wdp[t];
            dec_wire++;
            if (ones == 6) begin
                ones = 0;
                if (b) dec_stuff_err++;
            end else begin
                cur[nb] = b;
                nb++;
                ones = b ? ones + 1 : 0;
                if (nb == 8) begin
                    dec_bytes[dec_n] = cur;
                    dec_n++;
                    nb = 0;
                end
            end
            t += CPB;
        end
        dec_left = nb;
    endtask

    task automatic run_packet(input int exp_wire, input int exp_err, input int mid_at);
        int c0;
        int k;
        base = pops;
        @(negedge clk);
        transmit_start = 1'b1;
        c0 = cyc;
        re_cnt = 0;
        err_cnt = 0;
        build_expect(c0 + 1);
        if (exp_wire >= 0) check("model wire bits", model_bits, exp_wire);
        @(negedge clk);
        transmit_start = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 6000) begin
            @(negedge clk);
            k++;
            transmit_start = (k == mid_at);
        end
        transmit_start = 1'b0;
        if (exp_q.size() != 0) begin
            check("packet timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        decode(c0 + 3);
        if (exp_wire >= 0) check("wire bit count", dec_wire, exp_wire);
        check("decoded byte count", dec_n, 2 * pkt_n);
        for (int i = 0; i < pkt_n && 2 * i + 1 < dec_n; i++) begin
            check("decoded hi byte", int'(dec_bytes[2 * i]),     int'(pkt_w[i][15:8]));
            check("decoded lo byte", int'(dec_bytes[2 * i + 1]), int'(pkt_w[i][7:0]));
        end
        check("leftover bits", dec_left, 0);
        check("stuff bit not zero", dec_stuff_err, 0);
        check("read_enable pulses", re_cnt, pkt_n);
        check("tx_error cycles", err_cnt, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset d_plus", d_plus_out, 1);
        check("reset d_minus", d_minus_out, 0);
        check("reset read_enable", read_enable, 0);
        check("reset tx_error", tx_error, 0);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        pkt_w[0] = 16'h80D2; pkt_w[1] = 16'h0001; pkt_w[2] = 16'h0203; pkt_n = 3;
        run_packet(48, 0, -1);

        pkt_w[0] = 16'h80C3; pkt_w[1] = 16'h2345; pkt_w[2] = 16'h6789; pkt_n = 3;
        run_packet(48, 0, -1);

        // 16 ones -> two stuffs; trailing six ones -> stuff before EOP
        pkt_w[0] = 16'h8069; pkt_w[1] = 16'hFFFF; pkt_w[2] = 16'h00FC; pkt_n = 3;
        run_packet(51, 0, -1);

        pkt_w[0]  = 16'h80D2;
        pkt_w[1]  = 16'h0000; pkt_w[2]  = 16'h0000; pkt_w[3]  = 16'h0000; pkt_w[4]  = 16'h80B6;
        pkt_w[5]  = 16'h1234; pkt_w[6]  = 16'h5678; pkt_w[7]  = 16'h9ABC; pkt_w[8]  = 16'hDEF0;
        pkt_w[9]  = 16'h0F1E; pkt_w[10] = 16'h2D3C; pkt_w[11] = 16'h4B5A; pkt_w[12] = 16'h6978;
        pkt_w[13] = 16'h8796; pkt_w[14] = 16'hA5B4; pkt_w[15] = 16'hF1A9; pkt_w[16] = 16'hF090;
        pkt_n = 17;
        run_packet(-1, 0, -1);

        pkt_w[0] = 16'h80C3; pkt_w[1] = 16'h2345; pkt_w[2] = 16'h6789; pkt_n = 3;
        run_packet(48, 1, 200);

        // Reset in the middle of word 1
        pkt_w[0] = 16'h80D2; pkt_w[1] = 16'h0001; pkt_w[2] = 16'h0203; pkt_n = 3;
        base = pops;
        @(negedge clk); transmit_start = 1'b1;
        @(negedge clk); transmit_start = 1'b0;
        repeat (200) @(negedge clk);
        p0 = pops - base;
        check("pops before reset", p0, 2);
        n_rst = 1'b0;
        #1;
        check("read_enable in reset", read_enable, 0);
        @(negedge clk);
        check("reset mid d_plus", d_plus_out, 1);
        check("reset mid d_minus", d_minus_out, 0);
        check("reset mid read_enable", read_enable, 0);
        @(negedge clk);
        n_rst = 1'b1;
        check("no pop during reset", pops - base, 2);
        repeat (3) @(negedge clk);
        check("idle after reset d_plus", d_plus_out, 1);
        run_packet(48, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_tx_top_level.md
# usb_tx_top_level

USB full-speed style serial transmitter. It takes 16-bit words from an upstream transmit FIFO and drives NRZI-encoded, bit-stuffed differential D+/D− lines, ending each packet with EOP. It sits between the miner's result FIFO and the USB wire, and its output is loop-back compatible with the team's USB receiver.

## Interface
- CLKS_PER_BIT, default 8, clocks per bus bit time (80 ns at a 10 ns clock).
- clk  in  1  system clock, all logic on rising edge.
- n_rst  in  1  reset, synchronous and active-low.
- tx_data  in  16  FIFO head word. Word 0 of a packet is SYNC in [15:8] (0x80) and PID in [7:0].
- transmit_empty  in  1  FIFO empty; sampled only at word boundaries.
- transmit_start  in  1  level/pulse; starts a packet when idle.
- d_plus_out  out  1  D+ line.
- d_minus_out  out  1  D− line.
- read_enable  out  1  one-cycle pop strobe; asserted in the cycle tx_data is latched.
- tx_error  out  1  one-cycle pulse: transmit_start seen while a packet is in progress.

## Operation
- States: IDLE, LOAD, SEND, STUFF, EOP_SE0, EOP_J.
- **IDLE**
  - Lines at J (d+=1, d−=0).
  - On transmit_start=1, go to LOAD.
- **LOAD** (1 cycle)
  - Latch tx_data into a 16-bit shift register and pulse read_enable.
  - The FIFO then presents the next word.
- **SEND**
  - Per-word bit order: byte [15:8] first, then [7:0]; each byte LSB first (bits 8..15, then 0..7).
  - NRZI: data 0 toggles the line state; data 1 holds it.
  - Each bit is held CLKS_PER_BIT clocks.
  - The NRZI state starts at J for every packet.
- **STUFF**
  - After six consecutive transmitted 1s (count spans word boundaries), insert one 0 bit (a toggle) and reset the count.
  - Any transmitted 0 also resets the count.
  - Stuff bits are not counted among the 16 word bits.
  - A stuff bit due after a word's last bit is sent before the next word or before EOP.
- **Word boundary** (end of bit 15's period, after any pending stuff bit)
  - If transmit_empty=0: latch tx_data and pulse read_enable in that cycle; the next word's first bit starts the following cycle with no gap.
  - If transmit_empty=1: go to EOP_SE0.
- **EOP_SE0**: d+=0, d−=0 for 2 bit times.
- **EOP_J**: J for 1 bit time, then IDLE.
- No CRC is generated; any CRC bytes are supplied as payload words.
- transmit_start while not IDLE is ignored and pulses tx_error for one cycle.
- Reset values: d_plus_out=1, d_minus_out=0, read_enable=0, tx_error=0, state IDLE, bit counters and stuff counter 0.
- Reset mid-packet returns the lines to J on the next clock with no EOP; the FIFO is not popped.

## Timing
- transmit_start sampled at edge N → LOAD at N+1 (read_enable=1) → first SYNC bit on the lines from edge N+2.
- read_enable is exactly one cycle wide per word: one pulse for word 0 plus one per payload word.
- Word period is 16×CLKS_PER_BIT clocks plus CLKS_PER_BIT per inserted stuff bit.
- EOP lasts 3×CLKS_PER_BIT clocks (2 SE0 + 1 J).
- A new transmit_start is accepted in the first IDLE cycle after EOP_J.
- Outputs are registered; no combinational path from inputs to d_plus_out/d_minus_out.

## Structure
- Package usb_pkg holds:
  - CLKS_PER_BIT default;
  - SYNC_BYTE=8'h80;
  - PID constants ACK=8'hD2, DATA0=8'hC3;
  - state enum type.
- Sub-module usb_tx_encoder: bit-timer, NRZI state, stuff counter and line drive. It takes a serial bit plus a bit-valid strobe and returns a bit-done strobe.
- The top level contains the FSM, shift register and FIFO handshake.

## Test plan
- Reset: n_rst=0 for 2 clocks → d+=1, d−=0, read_enable=0, tx_error=0.
- tx_data=16'h80D2, pulse transmit_start; FIFO supplies 16'h0001, 16'h0203, then transmit_empty=1.
  - Wire decodes to 00000001, PID D2, bytes 00 01 02 03.
  - Then SE0 for 16 clocks, J for 8 clocks.
  - Exactly 3 read_enable pulses.
- PID C3 with payload 16'h2345, 16'h6789 → decoded bytes C3 23 45 67 89, then EOP.
- Payload 16'hFFFF → a 0 is inserted after each sixth 1 (two stuff bits for 16 ones after PID); bit count on the wire increases by 2.
- 256-bit hash 0x00000000000080b6…f1a9f090 as 16 words → loop-back receiver reports PID D2 then 32 bytes in order (00 00 … f0 90); 17 read_enable pulses.
- transmit_start reasserted mid-payload → tx_error high one cycle; packet bytes unchanged.
- n_rst=0 mid-word → lines at J next cycle and read_enable=0; a subsequent transmit_start sends a clean packet.
